// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizing constants, pointer type and Gray conversion
package fifo_pkg;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int ADDR  = 5;
    typedef logic [ADDR:0] ptr_t;
    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrap-bit binary pointer with a registered Gray copy
module fifo_ptr import fifo_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output ptr_t binary,
    output ptr_t gray
);
    ptr_t nxt;
    assign nxt = binary + 1'b1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            binary <= '0;
            gray   <= '0;
        end else if (inc) begin
            binary <= nxt;
            gray   <= bin2gray(nxt);
        end
endmodule

// File: rtl/fifo_dut_wrapper.sv
// fifo_dut_wrapper: single-clock 32x32 FIFO with registered read data and status flags
module fifo_dut_wrapper import fifo_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic [ADDR:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t wb, wg, rb, rg;
    logic wr_ok, rd_ok;
    // Gray copies are kept for a future dual-clock variant
    logic unused_gray;
    assign unused_gray = ^{wg, rg};
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign empty = wb == rb;
    assign full  = (wb[ADDR] != rb[ADDR]) && (wb[ADDR-1:0] == rb[ADDR-1:0]);
    assign count = wb - rb;
    fifo_ptr wptr (.clk, .rst_n, .inc(wr_ok), .binary(wb), .gray(wg));
    fifo_ptr rptr (.clk, .rst_n, .inc(rd_ok), .binary(rb), .gray(rg));
    always_ff @(posedge clk)
        if (wr_ok) mem[wb[ADDR-1:0]] <= wr_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= mem[rb[ADDR-1:0]];
        end
endmodule

// File: tb/tb_fifo_dut_wrapper.sv
// tb_fifo_dut_wrapper: directed self-checking bench for fifo_dut_wrapper
module tb_fifo_dut_wrapper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic [5:0]  count;
    int tests = 0;
    int fails = 0;

    fifo_dut_wrapper dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_rd;
        logic        we, re, prev_msb;
        int          nw, toggles;
        #12;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_empty", empty, 1);

        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1;
            wr_data = i;
            tick();
            if (i == 0) begin
                check("first_wr_empty", empty, 0);
                check("first_wr_count", count, 1);
            end
            if (i == 30) check("almost_full", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_count", count, 32);
        wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        check("drop_count", count, 32);
        check("drop_wptr", dut.wptr.binary, 32);
        check("drop_rptr", dut.rptr.binary, 0);

        rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("rd_seq_data", rd_data, i);
            check("rd_seq_valid", rd_valid, 1);
        end
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);
        tick();
        rd_en = 1'b0;
        check("rd_empty_valid", rd_valid, 0);
        check("rd_empty_hold", rd_data, 32'h1F);

        nw = 0;
        toggles = 0;
        for (int cyc = 0; cyc < 400 && (nw < 100 || q.size() > 0); cyc++) begin
            we = (nw < 100) && (q.size() < 20);
            re = (q.size() >= 5) || (nw == 100 && q.size() > 0);
            wr_en = we;
            rd_en = re;
            wr_data = 32'h1000 + nw * 3;
            if (re) exp_rd = q.pop_front();
            if (we) begin
                q.push_back(wr_data);
                nw++;
            end
            prev_msb = dut.wptr.binary[5];
            tick();
            if (dut.wptr.binary[5] != prev_msb) toggles++;
            check("wrap_valid", rd_valid, re);
            if (re) check("wrap_data", rd_data, exp_rd);
            check("wrap_count", count, q.size());
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wrap_empty", empty, 1);
        check("wrap_msb_toggles", toggles, 3);
        check("wrap_wptr", dut.wptr.binary, 4);

        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 32'hA5;
        tick();
        rd_en = 1'b0;
        check("sim_empty_count", count, 1);
        check("sim_empty_valid", rd_valid, 0);
        for (int k = 1; k < 32; k++) begin
            wr_data = 32'h200 + k;
            tick();
        end
        check("sim_full_flag", full, 1);
        rd_en = 1'b1;
        wr_data = 32'hBAD;
        tick();
        wr_en = 1'b0;
        check("sim_full_valid", rd_valid, 1);
        check("sim_full_data", rd_data, 32'hA5);
        check("sim_full_wptr", dut.wptr.binary, 4 + 32);
        for (int k = 1; k <= 21; k++) begin
            tick();
            check("sim_drain_data", rd_data, 32'h200 + k);
        end
        check("sim_mid_count", count, 10);
        wr_en = 1'b1;
        wr_data = 32'hC0DE;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim_mid_count_hold", count, 10);
        check("sim_mid_data", rd_data, 32'h216);
        check("sim_mid_valid", rd_valid, 1);

        wr_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wr_data = 32'h300 + k;
            tick();
        end
        wr_en = 1'b0;
        check("pre_rst_count", count, 17);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_empty", empty, 1);
        check("async_rst_count", count, 0);
        check("async_rst_full", full, 0);
        check("async_rst_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
